// File: rtl/imm_gen_buf_if.sv
// imm_gen_buf_if: instruction push and decoded-immediate pop handshakes for imm_gen_buf
interface imm_gen_buf_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
);
  localparam int LW = $clog2(DEPTH + 1);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     inst;
  logic            ext_sel;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] imm;
  logic [2:0]      fmt;
  logic            illegal;
  logic [LW-1:0]   level;
  modport master (
    output in_valid, inst, ext_sel, out_ready,
    input  in_ready, out_valid, imm, fmt, illegal, level
  );
  modport slave (
    input  in_valid, inst, ext_sel, out_ready,
    output in_ready, out_valid, imm, fmt, illegal, level
  );
endinterface

// File: rtl/imm_gen_buf.sv
// imm_gen_buf: RISC-V immediate decoder feeding a DEPTH-entry result FIFO
module imm_gen_buf #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input logic         clk,
  input logic         rst_n,
  input logic         flush,
  imm_gen_buf_if.slave bus
);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [2:0] F_NONE = 3'd0;
  localparam logic [2:0] F_I = 3'd1;
  localparam logic [2:0] F_S = 3'd2;
  localparam logic [2:0] F_B = 3'd3;
  localparam logic [2:0] F_U = 3'd4;
  localparam logic [2:0] F_J = 3'd5;
  localparam logic [2:0] F_Z = 3'd6;
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [LW-1:0]   level;
  logic [XLEN-1:0] mem_imm [DEPTH];
  logic [2:0]      mem_fmt [DEPTH];
  logic            mem_ill [DEPTH];
  logic            push, pop, s;
  logic [63:0]     d_imm;
  logic [2:0]      d_fmt;
  logic            d_ill;
  logic [31:0]     i;
  assign i = bus.inst;
  assign s = bus.ext_sel & i[31];
  assign push = bus.in_valid & bus.in_ready;
  assign pop = bus.out_valid & bus.out_ready;
  assign bus.in_ready = level < LW'(DEPTH);
  assign bus.out_valid = level != '0;
  assign bus.imm = bus.out_valid ? mem_imm[rd_ptr] : '0;
  assign bus.fmt = bus.out_valid ? mem_fmt[rd_ptr] : F_NONE;
  assign bus.illegal = bus.out_valid & mem_ill[rd_ptr];
  assign bus.level = level;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  // decode at full 64-bit width, truncated to XLEN on store
  always_comb begin
    d_imm = '0;
    d_fmt = F_NONE;
    d_ill = 1'b0;
    case (i[6:0])
      7'b0010011, 7'b0000011, 7'b1100111: begin
        d_imm = {{52{s}}, i[31:20]};
        d_fmt = F_I;
      end
      7'b0011011: begin
        d_imm = XLEN == 64 ? {{52{s}}, i[31:20]} : '0;
        d_fmt = XLEN == 64 ? F_I : F_NONE;
        d_ill = XLEN != 64;
      end
      7'b0100011: begin
        d_imm = {{52{s}}, i[31:25], i[11:7]};
        d_fmt = F_S;
      end
      7'b1100011: begin
        d_imm = {{51{s}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
        d_fmt = F_B;
      end
      7'b0110111, 7'b0010111: begin
        d_imm = {{32{s}}, i[31:12], 12'd0};
        d_fmt = F_U;
      end
      7'b1101111: begin
        d_imm = {{43{s}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
        d_fmt = F_J;
      end
      7'b1110011: begin
        d_imm = i[14] ? {59'd0, i[19:15]} : '0;
        d_fmt = i[14] ? F_Z : F_NONE;
      end
      default: d_ill = 1'b1;
    endcase
  end
  // pointer and occupancy bookkeeping; flush wins over push/pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level <= '0;
    end else begin
      if (push) wr_ptr <= inc(wr_ptr);
      if (pop) rd_ptr <= inc(rd_ptr);
      level <= level + LW'(push) - LW'(pop);
    end
  end
  // result storage; contents are masked by out_valid so need no reset
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_imm[wr_ptr] <= d_imm[XLEN-1:0];
      mem_fmt[wr_ptr] <= d_fmt;
      mem_ill[wr_ptr] <= d_ill;
    end
  end
endmodule
